// File: rtl/id_allocator_pkg.sv
// Shared types and sizing for the instruction ID tracking scheme.
// MAX_IDS must be a power of two, at least 2.
package id_allocator_pkg;

   localparam int MAX_IDS = 8;
   localparam int ID_W    = $clog2(MAX_IDS);
   localparam int CNT_W   = $clog2(MAX_IDS + 1);

   typedef logic [ID_W-1:0]  id_t;
   typedef logic [CNT_W-1:0] id_count_t;

   // Next ID in round-robin order, wrapping by natural overflow.
   function automatic id_t id_next(input id_t id);
      return id + 1'b1;
   endfunction

endpackage

// File: rtl/id_toggle_bank.sv
// Bank of N toggle bits; one bit may flip per cycle.
// Ports: clk, rst (sync, high), toggle_en, toggle_idx, bits.
module id_toggle_bank #(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 toggle_en,
   input  logic [$clog2(N)-1:0] toggle_idx,
   output logic [N-1:0]         bits
);

   always_ff @(posedge clk) begin
      if (rst) begin
         bits <= '0;
      end else if (toggle_en) begin
         bits[toggle_idx] <= ~bits[toggle_idx];
      end
   end

endmodule

// File: rtl/id_allocator.sv
// Round-robin instruction ID allocator with out-of-order retire.
// Ports: clk, rst, alloc_req/valid/id, retire/retire_id,
// query_id/query_inflight, outstanding, full, empty, and
// retire_error when ID_ALLOC_ERROR_EN is defined.
module id_allocator
   import id_allocator_pkg::*;
#(
   parameter int MAX_IDS = id_allocator_pkg::MAX_IDS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_req,
   output logic                         alloc_valid,
   output logic [$clog2(MAX_IDS)-1:0]   alloc_id,
   input  logic                         retire,
   input  logic [$clog2(MAX_IDS)-1:0]   retire_id,
   input  logic [$clog2(MAX_IDS)-1:0]   query_id,
   output logic                         query_inflight,
   output logic [$clog2(MAX_IDS+1)-1:0] outstanding,
   output logic                         full,
   output logic                         empty
`ifdef ID_ALLOC_ERROR_EN
   ,
   output logic                         retire_error
`endif
);

   localparam int IW = $clog2(MAX_IDS);
   localparam int CW = $clog2(MAX_IDS + 1);

   logic [MAX_IDS-1:0] issue_tog;
   logic [MAX_IDS-1:0] retire_tog;
   logic [MAX_IDS-1:0] inflight;
   logic [IW-1:0]      next_id;
   logic [CW-1:0]      count;
   logic               alloc_fire;
   logic               retire_fire;

   assign inflight    = issue_tog ^ retire_tog;
   assign alloc_fire  = alloc_req && !inflight[next_id];
   assign retire_fire = retire && inflight[retire_id];

   id_toggle_bank #(.N(MAX_IDS)) u_issue (
      .clk        (clk),
      .rst        (rst),
      .toggle_en  (alloc_fire),
      .toggle_idx (next_id),
      .bits       (issue_tog)
   );

   id_toggle_bank #(.N(MAX_IDS)) u_retire (
      .clk        (clk),
      .rst        (rst),
      .toggle_en  (retire_fire),
      .toggle_idx (retire_id),
      .bits       (retire_tog)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         next_id <= '0;
         count   <= '0;
      end else begin
         if (alloc_fire)
            next_id <= next_id + 1'b1;
         // Simultaneous alloc and retire cancel out.
         if (alloc_fire && !retire_fire)
            count <= count + 1'b1;
         else if (retire_fire && !alloc_fire)
            count <= count - 1'b1;
      end
   end

   assign alloc_id       = next_id;
   assign alloc_valid    = !inflight[next_id];
   assign query_inflight = inflight[query_id];
   assign outstanding    = count;
   assign full           = (count == CW'(MAX_IDS));
   assign empty          = (count == '0);

`ifdef ID_ALLOC_ERROR_EN
   always_ff @(posedge clk) begin
      if (rst)
         retire_error <= 1'b0;
      else if (retire && !inflight[retire_id])
         retire_error <= 1'b1;
   end

   a_count: assert property (@(posedge clk) disable iff (rst)
      count == CW'($countones(inflight)));

   a_full: assert property (@(posedge clk) disable iff (rst)
      full |-> !alloc_valid);
`endif

endmodule

// File: tb/tb_id_allocator.sv
// Self-checking bench for id_allocator (MAX_IDS = 8).
// Table vectors, corner sequences, random vs. a set model.
module tb_id_allocator;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_req;
   logic       alloc_valid;
   logic [2:0] alloc_id;
   logic       retire;
   logic [2:0] retire_id;
   logic [2:0] query_id;
   logic       query_inflight;
   logic [3:0] outstanding;
   logic       full;
   logic       empty;
`ifdef ID_ALLOC_ERROR_EN
   logic       retire_error;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: set of busy IDs plus the issue pointer.
   bit m_busy[N];
   int m_next;
   bit m_err;

   always #5 clk = ~clk;

   id_allocator #(.MAX_IDS(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_req      (alloc_req),
      .alloc_valid    (alloc_valid),
      .alloc_id       (alloc_id),
      .retire         (retire),
      .retire_id      (retire_id),
      .query_id       (query_id),
      .query_inflight (query_inflight),
      .outstanding    (outstanding),
      .full           (full),
      .empty          (empty)
`ifdef ID_ALLOC_ERROR_EN
      ,
      .retire_error   (retire_error)
`endif
   );

   typedef struct {
      bit req;
      bit ret;
      int rid;
      int qid;
      int e_valid;
      int e_id;
      int e_out;
      int e_q;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      foreach (m_busy[i]) c += m_busy[i];
      return c;
   endfunction

   // One clock with the currently driven inputs; model follows.
   task automatic step();
      bit fa, fr;
      int nx, rd;
      nx = m_next;
      rd = int'(retire_id);
      fa = alloc_req && !m_busy[nx];
      fr = retire && m_busy[rd];
      @(posedge clk);
      #1;
      if (rst) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_next = 0;
         m_err  = 0;
      end else begin
         if (retire && !m_busy[rd]) m_err = 1;
         if (fr) m_busy[rd] = 0;
         if (fa) begin
            m_busy[nx] = 1;
            m_next = (nx + 1) % N;
         end
      end
   endtask

   task automatic drive(bit req, bit ret, int rid, int qid);
      alloc_req = req;
      retire    = ret;
      retire_id = 3'(rid);
      query_id  = 3'(qid);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic alloc_n(int n);
      for (int i = 0; i < n; i++) begin
         drive(1, 0, 0, 0);
         step();
      end
   endtask

   task automatic chk_model(string tag);
      chk({tag, " valid"}, int'(alloc_valid), int'(!m_busy[m_next]));
      chk({tag, " id"}, int'(alloc_id), m_next);
      chk({tag, " out"}, int'(outstanding), m_count());
      chk({tag, " full"}, int'(full), int'(m_count() == N));
      chk({tag, " empty"}, int'(empty), int'(m_count() == 0));
      chk({tag, " query"}, int'(query_inflight),
          int'(m_busy[int'(query_id)]));
`ifdef ID_ALLOC_ERROR_EN
      chk({tag, " err"}, int'(retire_error), int'(m_err));
`endif
   endtask

   initial begin
      tbl[0]  = '{1, 0, 0, 0, 1, 1, 1, 1};
      tbl[1]  = '{1, 0, 0, 1, 1, 2, 2, 1};
      tbl[2]  = '{1, 0, 0, 2, 1, 3, 3, 1};
      tbl[3]  = '{1, 0, 0, 2, 1, 4, 4, 1};
      tbl[4]  = '{0, 1, 2, 2, 1, 4, 3, 0};
      tbl[5]  = '{0, 1, 0, 0, 1, 4, 2, 0};
      tbl[6]  = '{0, 1, 6, 6, 1, 4, 2, 0};
      tbl[7]  = '{1, 0, 0, 4, 1, 5, 3, 1};
      tbl[8]  = '{1, 1, 1, 5, 1, 6, 3, 1};
      tbl[9]  = '{0, 0, 0, 1, 1, 6, 3, 0};
      tbl[10] = '{1, 1, 3, 3, 1, 7, 3, 0};

      rst = 1'b0;
      drive(0, 0, 0, 0);
      do_reset();

      chk("rst valid", int'(alloc_valid), 1);
      chk("rst id", int'(alloc_id), 0);
      chk("rst out", int'(outstanding), 0);
      chk("rst full", int'(full), 0);
      chk("rst empty", int'(empty), 1);
      chk("rst query", int'(query_inflight), 0);
`ifdef ID_ALLOC_ERROR_EN
      chk("rst err", int'(retire_error), 0);
`endif

      foreach (tbl[i]) begin
         drive(tbl[i].req, tbl[i].ret, tbl[i].rid, tbl[i].qid);
         step();
         chk($sformatf("vec%0d valid", i), int'(alloc_valid),
             tbl[i].e_valid);
         chk($sformatf("vec%0d id", i), int'(alloc_id), tbl[i].e_id);
         chk($sformatf("vec%0d out", i), int'(outstanding),
             tbl[i].e_out);
         chk($sformatf("vec%0d query", i), int'(query_inflight),
             tbl[i].e_q);
      end

      // Fill all IDs, stall, retire 0, reissue 0.
      do_reset();
      alloc_n(8);
      chk("fill full", int'(full), 1);
      chk("fill valid", int'(alloc_valid), 0);
      chk("fill id", int'(alloc_id), 0);
      chk("fill out", int'(outstanding), 8);
      alloc_n(1);
      chk("stall out", int'(outstanding), 8);
      chk("stall id", int'(alloc_id), 0);
      drive(0, 1, 0, 0);
      step();
      chk("free0 valid", int'(alloc_valid), 1);
      chk("free0 full", int'(full), 0);
      drive(1, 0, 0, 0);
      step();
      chk("reissue full", int'(full), 1);
      chk("reissue id", int'(alloc_id), 1);
      chk("reissue q0", int'(query_inflight), 1);

      // Wrap, then in-order stall on ID 1 while ID 2 is free.
      do_reset();
      alloc_n(4);
      drive(0, 1, 2, 2);
      step();
      drive(0, 1, 0, 0);
      step();
      chk("wrap q0", int'(query_inflight), 0);
      chk("wrap id4", int'(alloc_id), 4);
      chk("wrap out2", int'(outstanding), 2);
      alloc_n(4);
      chk("wrap id0", int'(alloc_id), 0);
      chk("wrap valid0", int'(alloc_valid), 1);
      alloc_n(1);
      chk("wrap id1", int'(alloc_id), 1);
      chk("wrap stall", int'(alloc_valid), 0);
      drive(1, 0, 0, 2);
      step();
      chk("wrap q2", int'(query_inflight), 0);
      chk("wrap out7", int'(outstanding), 7);

      // Illegal retire of ID 6.
      do_reset();
      drive(0, 1, 6, 6);
      step();
      chk("bad out", int'(outstanding), 0);
      chk("bad q6", int'(query_inflight), 0);
      chk("bad id", int'(alloc_id), 0);
`ifdef ID_ALLOC_ERROR_EN
      chk("bad err", int'(retire_error), 1);
      drive(0, 0, 0, 0);
      step();
      chk("bad err hold", int'(retire_error), 1);
      do_reset();
      chk("bad err clr", int'(retire_error), 0);
`endif

      // Reset with 5 outstanding.
      do_reset();
      alloc_n(5);
      chk("pre rst out", int'(outstanding), 5);
      do_reset();
      chk("mid rst out", int'(outstanding), 0);
      chk("mid rst empty", int'(empty), 1);
      chk("mid rst id", int'(alloc_id), 0);
      for (int q = 0; q < N; q++) begin
         query_id = 3'(q);
         #1;
         chk($sformatf("mid rst q%0d", q), int'(query_inflight), 0);
      end

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 9) < 6,
               $urandom_range(0, 9) < 5,
               int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, N - 1)));
         step();
         chk_model($sformatf("rnd%0d", c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/id_allocator.md
# id_allocator

Issues instruction IDs in round-robin order and accepts their out-of-order retirement, tracking each ID's in-flight status as the XOR of an issue-toggle bit and a retire-toggle bit. It is the allocating end of the per-ID toggle tracking scheme. Decode/issue sits upstream and requests IDs; writeback/commit returns them. It also reports occupancy and per-ID status to the rest of the pipeline.

## Interface
Parameters:
- MAX_IDS, default taiga_config::MAX_IDS; number of IDs; must be a power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- alloc_req  input  1  request for a new ID this cycle
- alloc_valid  output  1  alloc_id is free and may be taken
- alloc_id  output  id_t  candidate ID; consumed when alloc_req && alloc_valid
- retire  input  1  an ID is being returned this cycle
- retire_id  input  id_t  ID being returned
- query_id  input  id_t  ID whose status is read
- query_inflight  output  1  query_id is currently allocated
- outstanding  output  $clog2(MAX_IDS+1)  number of allocated IDs
- full  output  1  outstanding == MAX_IDS
- empty  output  1  outstanding == 0
- retire_error  output  1  sticky; present only with ID_ALLOC_ERROR_EN

## Operation
- State: issue_toggle[MAX_IDS], retire_toggle[MAX_IDS], next_id (id_t), outstanding counter.
- inflight[i] = issue_toggle[i] ^ retire_toggle[i].
- alloc_id = next_id. alloc_valid = !inflight[next_id].
- Allocation fires when alloc_req && alloc_valid:
  - issue_toggle[next_id] flips.
  - next_id advances by 1 and wraps from MAX_IDS-1 to 0 using natural id_t overflow.
- alloc_req while !alloc_valid: no state change. The requester holds or drops the request freely; there is no registered commitment.
- Retirement fires when retire && inflight[retire_id]: retire_toggle[retire_id] flips.
- retire of a non-inflight ID is ignored; no toggle flips.
- outstanding: +1 on an allocation fire, −1 on a retirement fire, unchanged when both or neither fire.
- Allocation is strictly in order. If next_id is still in flight, allocation stalls even when other IDs are free. This keeps IDs age-ordered.
- query_inflight = inflight[query_id], combinational from registers.

## Timing
- Reset: all toggles 0, next_id=0, outstanding=0, alloc_valid=1, alloc_id=0, query_inflight=0, full=0, empty=1, retire_error=0.
- All state updates on posedge clk. All outputs are combinational from registered state only; there is no input-to-output path.
- Allocation latency: an ID taken in cycle N shows as in flight from N+1.
- Retire latency: an ID retired in cycle N is free from N+1. If it equals next_id, alloc_valid rises in N+1 (no same-cycle bypass).
- Allocate and retire in the same cycle: both take effect, including when retire_id ≠ next_id, and outstanding is unchanged. A retire of the ID being allocated in that cycle cannot happen, because that ID is not in flight.
- Full: outstanding==MAX_IDS implies inflight[next_id], so alloc_valid=0.
- Reset mid-operation: all IDs become free. Upstream and downstream must flush in the same cycle.

## Configuration
- ID_ALLOC_ERROR_EN defined:
  - retire_error sets on the cycle after retire && !inflight[retire_id].
  - It stays set until rst.
  - Simulation assertions also check that outstanding equals popcount(inflight).
- ID_ALLOC_ERROR_EN undefined:
  - retire_error port is absent; illegal retires are silently ignored.
  - No assertions are compiled.

## Structure
- id_t and MAX_IDS come from taiga_types/taiga_config.
- Add to taiga_types: id_count_t, sized $clog2(MAX_IDS+1), used for outstanding.
- Sub-module id_toggle_bank, instantiated twice (issue and retire):
  - Contents: a MAX_IDS-bit register with synchronous reset to 0.
  - Inputs: one toggle enable and one toggle index.
  - Output: the full bit vector, so inflight can be formed by XOR.

## Test plan
- Reset, then alloc_req held for 4 cycles -> alloc_id 0,1,2,3 taken; outstanding=4; query_inflight(2)=1.
- MAX_IDS=8: allocate 8 with no retires -> full=1, alloc_valid=0, alloc_id=0; retire 0 -> alloc_valid=1 the next cycle, ID 0 reissued, full=1 again.
- Allocate 0–3, retire 2 then 0 -> query_inflight(2)=0 and (0)=0; next_id=4; outstanding=2. Then allocate through ID 7 and wrap -> ID 0 issued, then stall on ID 1 while ID 2 stays unused.
- Same cycle alloc (ID 5) and retire ID 1 -> outstanding unchanged; inflight(5)=1 and inflight(1)=0 next cycle.
- Retire ID 6 when not in flight -> no state change; with ID_ALLOC_ERROR_EN, retire_error=1 the next cycle and held until rst.
- rst asserted with 5 IDs outstanding -> next cycle outstanding=0, empty=1, alloc_id=0, all query_inflight=0.
